// File: rtl/rr_fifo_router.sv
// Multi-channel ingress router: one FIFO per input channel, fair round-robin
// selection into a single registered output stage drained by a yumi consumer.
module rr_fifo_router #(
    parameter int unsigned NUM_IN       = 4,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IN-1:0]           in_valid_i,
    input  logic [NUM_IN*DATA_W-1:0]    in_data_i,
    output logic [NUM_IN-1:0]           in_ready_o,
    output logic [DATA_W-1:0]           data_o,
    output logic [$clog2(NUM_IN)-1:0]   src_o,
    output logic                        valid_o,
    input  logic                        yumi_i,
    output logic                        busy_o
);

    localparam int unsigned SRC_W = $clog2(NUM_IN);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem    [NUM_IN][DEPTH];
    logic [CNT_W-1:0]  count  [NUM_IN];
    logic [PTR_W-1:0]  wr_ptr [NUM_IN];
    logic [PTR_W-1:0]  rd_ptr [NUM_IN];

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant;
    logic [SRC_W-1:0]  scan_idx;
    logic              found;
    logic              load_en;
    logic              afull;
    logic [NUM_IN-1:0] push;
    logic [NUM_IN-1:0] pop;
    logic [DATA_W-1:0] head;

    // Acceptance depends only on registered occupancy, so a full FIFO never
    // takes a word even in a cycle where it is also being popped.
    always_comb begin
        in_ready_o = '0;
        push       = '0;
        afull      = 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            in_ready_o[i] = (count[i] < CNT_W'(DEPTH));
            push[i]       = in_valid_i[i] & in_ready_o[i];
            if (count[i] >= CNT_W'(AFULL_THRESH)) begin
                afull = 1'b1;
            end
        end
    end

    // First non-empty channel at or after rr_ptr, wrapping modulo NUM_IN.
    always_comb begin
        found    = 1'b0;
        grant    = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            scan_idx = SRC_W'((32'(rr_ptr) + k) % NUM_IN);
            if (!found && (count[scan_idx] != '0)) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
    end

    always_comb begin
        load_en = found & (~valid_o | yumi_i);
        pop     = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            pop[i] = load_en & (grant == SRC_W'(i));
        end
        head = mem[grant][rd_ptr[grant]];
    end

    // Payload storage carries no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data_i[i*int'(DATA_W) +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CNT_W'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    // Output stage: reload on grant, otherwise drop valid once the word is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            src_o   <= '0;
            valid_o <= 1'b0;
            rr_ptr  <= '0;
            busy_o  <= 1'b0;
        end else begin
            busy_o <= afull;
            if (load_en) begin
                data_o  <= head;
                src_o   <= grant;
                valid_o <= 1'b1;
                rr_ptr  <= (grant == SRC_W'(NUM_IN - 1)) ? '0 : grant + SRC_W'(1);
            end else if (yumi_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_IN); g++) begin : g_guard
        a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(push[g] && (count[g] == CNT_W'(DEPTH))));
        a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
            !(pop[g] && (count[g] == '0)));
    end

endmodule

// File: tb/tb_rr_fifo_router.sv
// Bench for rr_fifo_router: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_fifo_router;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AFULL  = 14;

    logic                     clk        = 1'b0;
    logic                     rst_n      = 1'b0;
    logic [NUM_IN-1:0]        in_valid_i = '0;
    logic [NUM_IN*DATA_W-1:0] in_data_i  = '0;
    logic                     yumi_i     = 1'b0;
    logic [NUM_IN-1:0]        in_ready_o;
    logic [DATA_W-1:0]        data_o;
    logic [1:0]               src_o;
    logic                     valid_o;
    logic                     busy_o;

    always #5 clk = ~clk;

    rr_fifo_router #(
        .NUM_IN(NUM_IN), .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFULL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
        .data_o(data_o), .src_o(src_o), .valid_o(valid_o),
        .yumi_i(yumi_i), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_err    = 0;
    bit done     = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: plain queues per channel plus an output word.
    logic [DATA_W-1:0] mq [NUM_IN][$];
    logic              m_valid = 1'b0;
    logic [DATA_W-1:0] m_data  = '0;
    logic [1:0]        m_src   = '0;
    logic              m_busy  = 1'b0;
    int                m_rr    = 0;
    logic [NUM_IN-1:0] m_acc;
    logic              m_bsy;
    int                m_g;
    int                m_c;

    function automatic logic [NUM_IN-1:0] m_ready();
        logic [NUM_IN-1:0] r;
        for (int i = 0; i < int'(NUM_IN); i++) r[i] = (mq[i].size() < int'(DEPTH));
        return r;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_IN); i++) mq[i].delete();
            m_valid = 1'b0; m_data = '0; m_src = '0; m_busy = 1'b0; m_rr = 0;
        end else begin
            m_acc = in_valid_i & m_ready();
            m_bsy = 1'b0;
            for (int i = 0; i < int'(NUM_IN); i++)
                if (mq[i].size() >= int'(AFULL)) m_bsy = 1'b1;
            m_g = -1;
            for (int k = 0; k < int'(NUM_IN); k++) begin
                m_c = (m_rr + k) % int'(NUM_IN);
                if (m_g < 0 && mq[m_c].size() > 0) m_g = m_c;
            end
            if (m_g >= 0 && (!m_valid || yumi_i)) begin
                m_data  = mq[m_g].pop_front();
                m_src   = 2'(m_g);
                m_valid = 1'b1;
                m_rr    = (m_g + 1) % int'(NUM_IN);
            end else if (m_valid && yumi_i) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < int'(NUM_IN); i++)
                if (m_acc[i]) mq[i].push_back(in_data_i[i*int'(DATA_W) +: DATA_W]);
            m_busy = m_bsy;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (!done) begin
            chk("valid_o",    64'(valid_o),    64'(m_valid));
            chk("data_o",     64'(data_o),     64'(m_data));
            chk("src_o",      64'(src_o),      64'(m_src));
            chk("busy_o",     64'(busy_o),     64'(m_busy));
            chk("in_ready_o", 64'(in_ready_o), 64'(m_ready()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int ch, input logic [DATA_W-1:0] v);
        in_data_i[ch*int'(DATA_W) +: DATA_W] = v;
    endtask

    task automatic do_reset();
        in_valid_i = '0;
        yumi_i     = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    int pushed;
    int ncons;
    int cyc;
    logic [1:0]        exp_src [3];
    logic [DATA_W-1:0] exp_dat [3];

    initial begin
        #1;
        chk("rst_valid", 64'(valid_o), 64'(0));
        chk("rst_data",  64'(data_o),  64'(0));
        chk("rst_src",   64'(src_o),   64'(0));
        chk("rst_busy",  64'(busy_o),  64'(0));
        chk("rst_ready", 64'(in_ready_o), 64'(4'b1111));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single channel stream on ch2 with consumer always taking.
        yumi_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_valid_i = (k < 5) ? 4'b0100 : 4'b0000;
            set_data(2, 32'(32'hA0 + k));
            tick();
            if (k == 0) begin
                chk("t1_no_bypass", 64'(valid_o), 64'(0));
            end else if (k <= 5) begin
                chk("t1_valid", 64'(valid_o), 64'(1));
                chk("t1_data",  64'(data_o),  64'(32'hA0 + k - 1));
                chk("t1_src",   64'(src_o),   64'(2));
            end else begin
                chk("t1_drained", 64'(valid_o), 64'(0));
            end
        end

        // Fairness: three words per channel, then drain.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            in_valid_i = 4'b1111;
            for (int i = 0; i < 4; i++) set_data(i, 32'(i * 16 + j));
            tick();
        end
        in_valid_i = '0;
        tick();
        tick();
        yumi_i = 1'b1;
        for (int n = 0; n < 12; n++) begin
            chk("t2_valid", 64'(valid_o), 64'(1));
            chk("t2_src",   64'(src_o),   64'(n % 4));
            chk("t2_data",  64'(data_o),  64'((n % 4) * 16 + n / 4));
            tick();
        end
        chk("t2_end", 64'(valid_o), 64'(0));
        yumi_i = 1'b0;

        // Backpressure on ch0 with a stuck consumer.
        for (int k = 0; k < 19; k++) begin
            in_valid_i = 4'b0001;
            set_data(0, 32'(32'h300 + k));
            tick();
            chk("t3_ready", 64'(in_ready_o[0]), 64'(k < 16));
            chk("t3_busy",  64'(busy_o),        64'(k >= 15));
            if (k >= 1) begin
                chk("t3_hold_valid", 64'(valid_o), 64'(1));
                chk("t3_hold_data",  64'(data_o),  64'(32'h300));
            end
        end
        in_valid_i = '0;

        // Full ch1 with simultaneous offer and consumption; 40-word ordering.
        do_reset();
        pushed = 0;
        ncons  = 0;
        cyc    = 0;
        while ((pushed < 40 || ncons < 40) && cyc < 400) begin
            yumi_i        = (cyc >= 18);
            in_valid_i    = (pushed < 40) ? 4'b0010 : 4'b0000;
            set_data(1, 32'(32'h400 + pushed));
            if (cyc == 18) chk("t4_full_no_accept", 64'(in_ready_o[1]), 64'(0));
            if (yumi_i && valid_o) begin
                chk("t4_order", 64'(data_o), 64'(32'h400 + ncons));
                ncons++;
            end
            m_acc = in_valid_i & m_ready();
            tick();
            if (m_acc[1]) pushed++;
            if (cyc == 18) chk("t4_accept_after_pop", 64'(in_ready_o[1]), 64'(1));
            cyc++;
        end
        chk("t4_count", 64'(ncons), 64'(40));
        in_valid_i = '0;
        yumi_i     = 1'b0;
        tick();

        // Reset while three channels hold data and the output is valid.
        in_valid_i = 4'b0111;
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < 3; i++) set_data(i, 32'(32'h700 + i * 16 + j));
            tick();
        end
        in_valid_i = '0;
        tick();
        chk("t5_pre_valid", 64'(valid_o), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 64'(valid_o),    64'(0));
        chk("t5_async_busy",  64'(busy_o),     64'(0));
        chk("t5_async_ready", 64'(in_ready_o), 64'(4'b1111));
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        yumi_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t5_silent", 64'(valid_o), 64'(0));
        end
        in_valid_i = 4'b1001;
        set_data(0, 32'h500);
        set_data(3, 32'h530);
        tick();
        in_valid_i = '0;
        chk("t5_push_edge", 64'(valid_o), 64'(0));
        tick();
        chk("t5_first_src",  64'(src_o),  64'(0));
        chk("t5_first_data", 64'(data_o), 64'(32'h500));
        tick();
        chk("t5_second_src", 64'(src_o),  64'(3));
        tick();
        chk("t5_end", 64'(valid_o), 64'(0));

        // Skip empty channels: move rr_ptr to 1, then load only ch3 and ch0.
        in_valid_i = 4'b0001;
        set_data(0, 32'h600);
        tick();
        in_valid_i = '0;
        tick();
        tick();
        tick();
        yumi_i = 1'b0;
        in_valid_i = 4'b1001;
        for (int j = 0; j < 2; j++) begin
            set_data(0, 32'(32'h610 + j));
            set_data(3, 32'(32'h630 + j));
            tick();
        end
        in_valid_i = '0;
        tick();
        chk("t6_first_src",  64'(src_o),  64'(3));
        chk("t6_first_data", 64'(data_o), 64'(32'h630));
        exp_src[0] = 2'd0; exp_dat[0] = 32'h610;
        exp_src[1] = 2'd3; exp_dat[1] = 32'h631;
        exp_src[2] = 2'd0; exp_dat[2] = 32'h611;
        yumi_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("t6_src",  64'(src_o),  64'(exp_src[n]));
            chk("t6_data", 64'(data_o), 64'(exp_dat[n]));
        end
        tick();
        chk("t6_end", 64'(valid_o), 64'(0));
        yumi_i = 1'b0;

        tick();
        done = 1'b1;
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
